// File: rtl/scan_doubler.sv
// scan_doubler: line-doubling scan converter between the palette stage and the
// video pins. Input pixels (RGB 3/3/2) arrive at clk/2, qualified by h_half.
// Each input line is captured into one half of a ping-pong line buffer. The
// previously completed line is replayed twice at the full clk rate, which
// doubles the line frequency for a 31 kHz VGA-class monitor.
//
// Optional feature macro: SCANLINE_EN. When it is defined, the second replay of
// each line (RUN1) is dimmed by shifting every colour channel right by one.
// When it is undefined, both replays are identical.
//
// Output timing: rgb/de/hs/vs appear two clocks after the out_x value that
// produced them. One clock is the read address register and one clock is the
// buffer data register.

module scan_doubler #(
  parameter int H_PIX_TOTAL = 384,
  parameter int H_ACTIVE    = 256,
  parameter int HS_START    = 272,
  parameter int HS_WIDTH    = 32,
  parameter int ADDR_W      = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       h_half,
  input  logic       video_valid,
  input  logic [2:0] r_sig,
  input  logic [2:0] g_sig,
  input  logic [1:0] b_sig,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [2:0] r_out,
  output logic [2:0] g_out,
  output logic [1:0] b_out,
  output logic       de_out,
  output logic       hs_out,
  output logic       vs_out
);

  localparam int X_W       = $clog2(H_PIX_TOTAL);
  localparam int LEN_W     = ADDR_W + 1;
  localparam int MEM_DEPTH = 2 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN0 = 2'd1,
    RUN1 = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Line start detection
  // ---------------------------------------------------------------------------
  logic hsync_q;
  logic line_start;

  assign line_start = hsync_in & ~hsync_q;

  // Delay hsync by one clock so that its rising edge can be detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= 1'b0;
    end else begin
      hsync_q <= hsync_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Write side: capture the incoming line into the current bank
  // ---------------------------------------------------------------------------
  logic             wr_bank;
  logic [LEN_W-1:0] wr_x;
  logic             wr_en;
  logic [ADDR_W:0]  wr_addr;

  // wr_x saturates at H_ACTIVE, so pixels beyond the stored width are dropped
  // and the write never wraps back over pixel 0.
  assign wr_en   = h_half & video_valid & ~line_start & (32'(wr_x) < 32'(H_ACTIVE));
  assign wr_addr = {wr_bank, wr_x[ADDR_W-1:0]};

  // Swap banks at every line start, and count stored pixels within the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_x    <= '0;
    end else if (line_start) begin
      wr_bank <= ~wr_bank;
      wr_x    <= '0;
    end else if (wr_en) begin
      wr_x <= wr_x + LEN_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Ping-pong line buffer. The contents are not reset; stale locations are
  // masked on the read side using the stored line length.
  // ---------------------------------------------------------------------------
  logic [7:0] line_mem [MEM_DEPTH];

  // Write port for the line buffer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_mem[wr_addr] <= {r_sig, g_sig, b_sig};
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: replay the completed line twice per input line period
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [X_W-1:0]   out_x;
  logic             armed;
  logic             show;
  logic             vs_line;
  logic [LEN_W-1:0] rd_len;
  logic             x_last;

  assign x_last = (32'(out_x) == 32'(H_PIX_TOTAL - 1));

  // The line-start edge always restarts RUN0, even when a wrap occurs in the
  // same cycle. The first line after reset shows a bank that was never filled,
  // so 'armed' keeps that line blank through 'show'. At every line start the
  // length of the line that is about to be replayed is latched, together with
  // vsync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      out_x   <= '0;
      armed   <= 1'b0;
      show    <= 1'b0;
      vs_line <= 1'b0;
      rd_len  <= '0;
    end else if (line_start) begin
      state   <= RUN0;
      out_x   <= '0;
      armed   <= 1'b1;
      show    <= armed;
      vs_line <= vsync_in;
      rd_len  <= wr_x;
    end else begin
      case (state)
        IDLE: begin
          out_x <= '0;
        end
        RUN0: begin
          if (x_last) begin
            state <= RUN1;
            out_x <= '0;
          end else begin
            out_x <= out_x + X_W'(1);
          end
        end
        RUN1: begin
          if (x_last) begin
            state <= IDLE;
            out_x <= '0;
          end else begin
            out_x <= out_x + X_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          out_x <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Position decode for the current out_x
  // ---------------------------------------------------------------------------
  logic [31:0] x_ext;
  logic        gate;
  logic        in_active;
  logic        in_hs;
  logic        in_fill;

  assign x_ext     = 32'(out_x);
  assign gate      = ((state == RUN0) || (state == RUN1)) & show;
  assign in_active = x_ext < 32'(H_ACTIVE);
  assign in_hs     = (x_ext >= 32'(HS_START)) && (x_ext < 32'(HS_START + HS_WIDTH));
  assign in_fill   = x_ext < 32'(rd_len);

  // ---------------------------------------------------------------------------
  // Stage 1: registered read address and control
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bank;
  logic              de_s1;
  logic              hs_s1;
  logic              vs_s1;
  logic              fill_s1;

  // Register the address into the bank that is not being written. The control
  // bits travel with the address so that they stay aligned with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
      rd_bank <= 1'b0;
      de_s1   <= 1'b0;
      hs_s1   <= 1'b0;
      vs_s1   <= 1'b0;
      fill_s1 <= 1'b0;
    end else begin
      rd_addr <= ADDR_W'(out_x);
      rd_bank <= ~wr_bank;
      de_s1   <= gate & in_active;
      hs_s1   <= gate & in_hs;
      vs_s1   <= gate & vs_line;
      fill_s1 <= in_fill;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: buffer data register and output control
  // ---------------------------------------------------------------------------
  logic [7:0] rd_data;
  logic       de_s2;
  logic       hs_s2;
  logic       vs_s2;
  logic       fill_s2;

  // Synchronous buffer read. It has no reset, which keeps it block-RAM friendly.
  always_ff @(posedge clk) begin
    rd_data <= line_mem[{rd_bank, rd_addr}];
  end

  // Output control registers. An async reset blanks the outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_s2   <= 1'b0;
      hs_s2   <= 1'b0;
      vs_s2   <= 1'b0;
      fill_s2 <= 1'b0;
    end else begin
      de_s2   <= de_s1;
      hs_s2   <= hs_s1;
      vs_s2   <= vs_s1;
      fill_s2 <= fill_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output shaping
  // ---------------------------------------------------------------------------
  logic [7:0] pix;

  // Pixels outside de, and pixels beyond the stored length of the line, read
  // as black.
  assign pix = (de_s2 & fill_s2) ? rd_data : 8'd0;

`ifdef SCANLINE_EN
  logic dim_s1;
  logic dim_s2;

  // Carry the second-replay flag alongside the pixel so the dimming lines up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dim_s1 <= 1'b0;
      dim_s2 <= 1'b0;
    end else begin
      dim_s1 <= (state == RUN1);
      dim_s2 <= dim_s1;
    end
  end

  assign {r_out, g_out, b_out} = dim_s2 ?
      {1'b0, pix[7:6], 1'b0, pix[4:3], 1'b0, pix[1]} : pix;
`else
  assign {r_out, g_out, b_out} = pix;
`endif

  assign de_out = de_s2;
  assign hs_out = hs_s2;
  assign vs_out = vs_s2;

endmodule
